// File: rtl/uart_tx_queue_pkg.sv
// Shared definitions for the UART transmit queue: handshake FSM encoding,
// UART status polarity and timeout-counter sizing.
package uart_tx_queue_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StLoad     = 2'd1,
        StWaitBusy = 2'd2,
        StWaitIdle = 2'd3
    } tx_state_e;

    localparam logic TX_STATUS_IDLE = 1'b1;

    // Counter only needs to reach ACK_TIMEOUT-2 (see the WAIT_BUSY compare).
    function automatic int unsigned tmr_width(input int unsigned timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Circular byte buffer with a separately tracked count, flush and a sticky
// overflow flag. Read data is the byte at the head of the queue.
module uart_tx_queue_sync_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic [7:0]      i_data,
    input  logic            i_pop,
    input  logic            i_flush,
    input  logic            i_clr_ovf,
    output logic [7:0]      o_data,
    output logic [ADDR_W:0] o_count,
    output logic            o_full,
    output logic            o_empty,
    output logic            o_overflow
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop_ok;
    logic w_drop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // Full is judged before any same-cycle pop; flush discards the push silently.
    assign w_push_ok = i_push & ~w_full & ~i_flush;
    assign w_pop_ok  = i_pop & ~w_empty & ~i_flush;
    assign w_drop    = i_push & w_full & ~i_flush;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (i_flush) begin
                r_rd_ptr <= r_wr_ptr;
            end else if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (i_flush) begin
                r_count <= '0;
            end else begin
                case ({w_push_ok, w_pop_ok})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_empty    = w_empty;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding the UART: buffers CPU writes and drains them one
// at a time through the TX_EN / TX_STATUS handshake, with an ack timeout.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic            sysclk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [7:0]      wr_data,
    input  logic            flush,
    input  logic            clr_err,
    input  logic            TX_STATUS,
    output logic [7:0]      UART_TXD,
    output logic            TX_EN,
    output logic [ADDR_W:0] count,
    output logic            full,
    output logic            empty,
    output logic            busy,
    output logic            overflow,
    output logic            tx_err
);

    localparam int unsigned       TMR_W    = tmr_width(ACK_TIMEOUT);
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(ACK_TIMEOUT - 2);

    tx_state_e        r_state;
    logic [7:0]       r_txd;
    logic             r_tx_en;
    logic [TMR_W-1:0] r_tmr;
    logic             r_tx_err;

    logic [7:0]      w_fifo_data;
    logic [ADDR_W:0] w_count;
    logic            w_full;
    logic            w_empty;
    logic            w_overflow;
    logic            w_uart_idle;
    logic            w_pop;
    logic            w_timeout;

    assign w_uart_idle = (TX_STATUS == TX_STATUS_IDLE);
    assign w_pop       = (r_state == StIdle) & ~w_empty & w_uart_idle & ~flush;
    // Counter is cleared in LOAD, so hitting TMR_LAST here lands ACK_TIMEOUT cycles after LOAD.
    assign w_timeout   = (r_state == StWaitBusy) & w_uart_idle & (r_tmr == TMR_LAST);

    uart_tx_queue_sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk      (sysclk),
        .i_rst      (reset),
        .i_push     (wr_en),
        .i_data     (wr_data),
        .i_pop      (w_pop),
        .i_flush    (flush),
        .i_clr_ovf  (clr_err),
        .o_data     (w_fifo_data),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_overflow (w_overflow)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_txd    <= 8'h00;
            r_tx_en  <= 1'b0;
            r_tmr    <= '0;
            r_tx_err <= 1'b0;
        end else begin
            r_tx_en <= 1'b0;

            if (w_timeout) begin
                r_tx_err <= 1'b1;
            end else if (clr_err) begin
                r_tx_err <= 1'b0;
            end

            case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        r_txd   <= w_fifo_data;
                        r_tx_en <= 1'b1;
                        r_state <= StLoad;
                    end
                end
                StLoad: begin
                    r_tmr   <= '0;
                    r_state <= StWaitBusy;
                end
                StWaitBusy: begin
                    if (!w_uart_idle) begin
                        r_state <= StWaitIdle;
                    end else if (w_timeout) begin
                        r_state <= StIdle;
                    end else begin
                        r_tmr <= r_tmr + 1'b1;
                    end
                end
                StWaitIdle: begin
                    if (w_uart_idle) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign UART_TXD = r_txd;
    assign TX_EN    = r_tx_en;
    assign count    = w_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign busy     = (r_state != StIdle);
    assign overflow = w_overflow;
    assign tx_err   = r_tx_err;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue: a per-cycle vector table for the basic
// handshake, then hand sequences against a small UART model.
module tb_uart_tx_queue;

    localparam int unsigned DEPTH       = 16;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned ACK_TIMEOUT = 64;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       clr_err;
    logic       tx_status;
    logic [7:0] UART_TXD;
    logic       TX_EN;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       tx_err;

    uart_tx_queue #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .sysclk    (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .clr_err   (clr_err),
        .TX_STATUS (tx_status),
        .UART_TXD  (UART_TXD),
        .TX_EN     (TX_EN),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .overflow  (overflow),
        .tx_err    (tx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // UART model: acts on the falling edge, away from the DUT's active edge.
    logic       manual    = 1'b1;
    logic       manual_ts = 1'b1;
    logic       ack_en    = 1'b1;
    logic       hold_busy = 1'b0;
    int         busy_len  = 10;
    int         busy_left = 0;
    int         en_bad    = 0;
    logic       prev_en   = 1'b0;
    logic [7:0] rx_q[$];

    initial begin
        tx_status = 1'b1;
        forever begin
            @(negedge clk);
            if (manual) begin
                tx_status = manual_ts;
            end else if (TX_EN) begin
                if (tx_status != 1'b1) en_bad++;
                if (prev_en) en_bad++;
                rx_q.push_back(UART_TXD);
                if (ack_en) begin
                    tx_status = 1'b0;
                    busy_left = busy_len;
                end
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_status = !hold_busy;
            end else begin
                tx_status = !hold_busy;
            end
            prev_en = TX_EN;
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(empty && !busy) && n < 400) begin
            step();
            n++;
        end
        check(name, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_tx_en(input string name);
        int n;
        n = 0;
        while (!TX_EN && n < 20) begin
            step();
            n++;
        end
        check(name, 32'(TX_EN), 32'd1);
    endtask

    typedef struct {
        logic       rst, wr;
        logic [7:0] data;
        logic       fl, clr, ts;
        logic       en;
        logic [7:0] txd;
        logic [4:0] cnt;
        logic       full, empty, busy, ovf, err;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic wr, input logic [7:0] data,
                                input logic fl, input logic clr, input logic ts,
                                input logic en, input logic [7:0] txd, input logic [4:0] cnt,
                                input logic fu, input logic em, input logic bu,
                                input logic ovf, input logic err);
        vec_t v;
        v.rst = rst; v.wr = wr; v.data = data; v.fl = fl; v.clr = clr; v.ts = ts;
        v.en = en; v.txd = txd; v.cnt = cnt; v.full = fu; v.empty = em; v.busy = bu;
        v.ovf = ovf; v.err = err;
        return v;
    endfunction

    vec_t       vecs[18];
    logic [7:0] peak;

    initial begin
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        flush   = 1'b0;
        clr_err = 1'b0;

        //                rst wr data  fl clr ts  en txd   cnt fu em bu ov er
        vecs[0]  = mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0, 0);
        vecs[1]  = mk(1, 0, 8'h00, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 1, 8'h55, 0, 0, 1, 0, 8'h00, 1, 0, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 8'h00, 0, 0, 1, 1, 8'h55, 0, 0, 1, 1, 0, 0);
        for (int i = 4; i < 14; i++) begin
            vecs[i] = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h55, 0, 0, 1, 1, 0, 0);
        end
        vecs[14] = mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h55, 0, 0, 1, 0, 0, 0);
        vecs[15] = mk(0, 0, 8'h00, 0, 1, 1, 0, 8'h55, 0, 0, 1, 0, 0, 0);
        vecs[16] = mk(0, 1, 8'h66, 1, 0, 1, 0, 8'h55, 0, 0, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 8'h00, 0, 0, 1, 0, 8'h55, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 18; i++) begin
            reset     = vecs[i].rst;
            wr_en     = vecs[i].wr;
            wr_data   = vecs[i].data;
            flush     = vecs[i].fl;
            clr_err   = vecs[i].clr;
            manual_ts = vecs[i].ts;
            step();
            check($sformatf("vec%0d", i),
                  32'({TX_EN, UART_TXD, count, full, empty, busy, overflow, tx_err}),
                  32'({vecs[i].en, vecs[i].txd, vecs[i].cnt, vecs[i].full, vecs[i].empty,
                       vecs[i].busy, vecs[i].ovf, vecs[i].err}));
        end
        reset = 1'b0; wr_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        manual = 1'b0;
        busy_len = 6;
        step();

        // Burst of five bytes, in order.
        rx_q.delete();
        peak = 8'h00;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'hA1 + i);
            step();
            if (8'(count) > peak) peak = 8'(count);
        end
        wr_en = 1'b0;
        wait_drain("burst_drain");
        check("burst_peak", 32'(peak == 8'd4 || peak == 8'd5), 32'd1);
        check("burst_n", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) check($sformatf("burst_b%0d", i), 32'(rx_q[i]), 32'(8'hA1 + i));
        end

        // Fill with the UART held busy, then overflow, clear and drain across the wrap.
        hold_busy = 1'b1;
        step(); step();
        rx_q.delete();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'hB0 + i);
            step();
        end
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd16);
        check("full_no_ovf", 32'(overflow), 32'd0);
        wr_data = 8'hFF;
        step();
        wr_en = 1'b0;
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd16);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        hold_busy = 1'b0;
        wait_drain("full_drain");
        check("full_n", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < rx_q.size()) check($sformatf("full_b%0d", i), 32'(rx_q[i]), 32'(8'hB0 + i));
        end

        // Push lands in the same cycle as the IDLE pop.
        hold_busy = 1'b1;
        step(); step();
        rx_q.delete();
        wr_en = 1'b1; wr_data = 8'h11;
        step();
        wr_en = 1'b0;
        check("pp_pre_count", 32'(count), 32'd1);
        hold_busy = 1'b0;
        wr_en = 1'b1; wr_data = 8'h3C;
        step();
        wr_en = 1'b0;
        check("pp_count", 32'(count), 32'd1);
        check("pp_txen", 32'({TX_EN, UART_TXD}), 32'({1'b1, 8'h11}));
        wait_drain("pp_drain");
        check("pp_n", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) check("pp_second", 32'(rx_q[1]), 32'h3C);

        // UART never acknowledges.
        ack_en = 1'b0;
        rx_q.delete();
        wr_en = 1'b1; wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        wait_tx_en("to_txen");
        begin
            int cyc;
            cyc = 0;
            while (!tx_err && cyc < 200) begin
                step();
                cyc++;
            end
            check("to_cycles", 32'(cyc), 32'(ACK_TIMEOUT));
        end
        check("to_busy", 32'(busy), 32'd0);
        ack_en = 1'b1;
        clr_err = 1'b1;
        wr_en = 1'b1; wr_data = 8'h78;
        step();
        clr_err = 1'b0; wr_en = 1'b0;
        check("to_clr", 32'(tx_err), 32'd0);
        wait_drain("to_drain");
        check("to_n", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() == 2) check("to_next", 32'(rx_q[1]), 32'h78);

        // Flush with one byte in flight and six queued.
        busy_len = 20;
        rx_q.delete();
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'hC1 + i);
            step();
        end
        check("fl_pre_count", 32'(count), 32'd6);
        flush = 1'b1; wr_data = 8'hEE;
        step();
        flush = 1'b0; wr_en = 1'b0;
        check("fl_state", 32'({count, empty, busy, overflow}), 32'({5'd0, 1'b1, 1'b1, 1'b0}));
        wait_drain("fl_drain");
        check("fl_n", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() == 1) check("fl_inflight", 32'(rx_q[0]), 32'hC1);

        // Reset while waiting for the UART to go idle.
        rx_q.delete();
        wr_en = 1'b1; wr_data = 8'h99;
        step();
        wr_en = 1'b0;
        wait_tx_en("rst_txen");
        step(); step();
        check("rst_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_outputs",
              32'({TX_EN, UART_TXD, count, full, empty, busy, overflow, tx_err}),
              32'({1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}));
        step();
        check("rst_after", 32'({TX_EN, busy}), 32'd0);
        check("en_protocol", 32'(en_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
